// File: rtl/perf_pkg.sv
// perf_pkg: shared definitions for the performance counter bank.
//   - Channel index constants for the core event map.
//   - Default channel count.
//   - sel_width(): width of a channel select, never less than one bit.
package perf_pkg;

  localparam int PERF_NUM_CH_DEFAULT = 8;

  localparam int PERF_CH_CYC  = 0;
  localparam int PERF_CH_JMP  = 1;
  localparam int PERF_CH_BCH  = 2;
  localparam int PERF_CH_BED  = 3;
  localparam int PERF_CH_BUB  = 4;
  localparam int PERF_CH_LU   = 5;
  localparam int PERF_CH_HIT  = 6;
  localparam int PERF_CH_FAIL = 7;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_counter_channel.sv
// perf_counter_channel: one event counter with wrap or saturate behaviour,
// a sticky overflow flag and, when PERFCNT_SNAPSHOT_EN is defined, a
// shadow register loaded from the live count on snap.
//
// Ports:
//   clk     in   core clock
//   rst     in   asynchronous active-high reset
//   inc     in   increment request (already qualified by the global enable)
//   clr     in   synchronous clear of count and overflow flag
//   snap    in   load shadow with the pre-edge live count (snapshot build)
//   rd_val  out  value presented to the readout mux (shadow or live count)
//   ovf     out  sticky overflow flag
//
// Configuration macro: PERFCNT_SNAPSHOT_EN
module perf_counter_channel
  import perf_pkg::*;
#(
  parameter int CntBit   = 32,
  parameter int Saturate = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              clr,
  input  logic              snap,
  output logic [CntBit-1:0] rd_val,
  output logic              ovf
);

  localparam logic [CntBit-1:0] One = CntBit'(1);

  logic [CntBit-1:0] count;
  logic              at_max;

  assign at_max = &count;

  // Count stage: clear has priority over increment. Incrementing from
  // all-ones always sets the flag; wrap mode rolls to zero, saturate mode
  // simply leaves the count untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (at_max) begin
        ovf <= 1'b1;
        if (Saturate == 0) begin
          count <= '0;
        end
      end else begin
        count <= count + One;
      end
    end
  end

`ifdef PERFCNT_SNAPSHOT_EN
  logic [CntBit-1:0] shadow;

  // Shadow stage: samples count before this edge's update, so a
  // simultaneous clr or increment does not leak into the capture.
  // clr deliberately leaves the shadow alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
    end else if (snap) begin
      shadow <= count;
    end
  end

  assign rd_val = shadow;
`else
  logic unused_snap;

  assign unused_snap = snap;
  assign rd_val      = count;
`endif

endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: parametrised bank of event counters for core
// performance statistics, with a selectable readout port, sticky overflow
// flags, wrap/saturate choice and an optional coherent snapshot.
//
// Ports:
//   clk         in   core clock
//   rst         in   asynchronous active-high reset
//   en          in   global count enable
//   evt         in   per-channel event strobes
//   clr         in   synchronous clear of counts, flags and snap_valid
//   snap        in   capture live counts into the shadow bank
//   sel         in   readout channel select
//   rd_data     out  selected value (shadow in snapshot build, else live)
//   rd_ovf      out  live overflow flag of the selected channel
//   ovf         out  sticky per-channel overflow flags
//   snap_valid  out  shadow holds a capture since last reset/clear
//
// Configuration macro: PERFCNT_SNAPSHOT_EN (builds the shadow bank).
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NumCh    = PERF_NUM_CH_DEFAULT,
  parameter int CntBit   = 32,
  parameter int Saturate = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NumCh-1:0]              evt,
  input  logic                          clr,
  input  logic                          snap,
  input  logic [sel_width(NumCh)-1:0]   sel,
  output logic [CntBit-1:0]             rd_data,
  output logic                          rd_ovf,
  output logic [NumCh-1:0]              ovf,
  output logic                          snap_valid
);

  localparam int SelBit = sel_width(NumCh);

  logic [CntBit-1:0] rd_val [NumCh];

  for (genvar g = 0; g < NumCh; g++) begin : g_ch
    perf_counter_channel #(
      .CntBit   (CntBit),
      .Saturate (Saturate)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .inc    (en & evt[g]),
      .clr    (clr),
      .snap   (snap),
      .rd_val (rd_val[g]),
      .ovf    (ovf[g])
    );
  end

`ifdef PERFCNT_SNAPSHOT_EN
  // snap wins over clr so a combined snap+clr leaves a valid capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_valid <= 1'b0;
    end else if (snap) begin
      snap_valid <= 1'b1;
    end else if (clr) begin
      snap_valid <= 1'b0;
    end
  end
`else
  assign snap_valid = 1'b0;
`endif

  // Readout: a select beyond the last channel matches nothing and reads 0.
  always_comb begin
    rd_data = '0;
    rd_ovf  = 1'b0;
    for (int i = 0; i < NumCh; i++) begin
      if (int'(sel) == i) begin
        rd_data = rd_val[i];
        rd_ovf  = ovf[i];
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: two instances (wrap and saturate, 6 channels,
// 8-bit counters) share one stimulus stream; a behavioural model tracks
// counts, flags, shadow and snap_valid and every output is compared after
// each clock edge for all select values including out-of-range ones.
module tb_perf_counter_bank;

  localparam int NCH = 6;
  localparam int CB  = 8;
  localparam int SB  = 3;
  localparam int MAXV = (1 << CB) - 1;

`ifdef PERFCNT_SNAPSHOT_EN
  localparam bit SNAP_BUILD = 1'b1;
`else
  localparam bit SNAP_BUILD = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [NCH-1:0] evt;
  logic           clr;
  logic           snap;
  logic [SB-1:0]  sel;

  logic [CB-1:0]  rd_w, rd_s;
  logic           ro_w, ro_s;
  logic [NCH-1:0] ovf_w, ovf_s;
  logic           sv_w, sv_s;

  always #20 clk = ~clk;

  perf_counter_bank #(.NumCh(NCH), .CntBit(CB), .Saturate(0)) dut_w (
    .clk(clk), .rst(rst), .en(en), .evt(evt), .clr(clr), .snap(snap),
    .sel(sel), .rd_data(rd_w), .rd_ovf(ro_w), .ovf(ovf_w), .snap_valid(sv_w)
  );

  perf_counter_bank #(.NumCh(NCH), .CntBit(CB), .Saturate(1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .evt(evt), .clr(clr), .snap(snap),
    .sel(sel), .rd_data(rd_s), .rd_ovf(ro_s), .ovf(ovf_s), .snap_valid(sv_s)
  );

  // Model state, index 0 = wrap instance, 1 = saturate instance.
  int mc  [2][NCH];
  int mo  [2][NCH];
  int msh [2][NCH];
  int msv;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NCH; i++) begin
        mc[k][i] = 0; mo[k][i] = 0; msh[k][i] = 0;
      end
    msv = 0;
  endtask

  // One rising edge worth of behaviour, from the rules of the block.
  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NCH; i++) begin
        if (SNAP_BUILD && snap) msh[k][i] = mc[k][i];
        if (clr) begin
          mc[k][i] = 0; mo[k][i] = 0;
        end else if (en && evt[i]) begin
          if (mc[k][i] == MAXV) mo[k][i] = 1;
          if (k == 0) mc[k][i] = (mc[k][i] + 1) % (MAXV + 1);
          else        mc[k][i] = (mc[k][i] + 1 > MAXV) ? MAXV : mc[k][i] + 1;
        end
      end
    if (SNAP_BUILD) begin
      if (snap) msv = 1;
      else if (clr) msv = 0;
    end
  endtask

  function automatic int exp_rd(input int k, input int s);
    if (s >= NCH) return 0;
    return SNAP_BUILD ? msh[k][s] : mc[k][s];
  endfunction

  function automatic int exp_ro(input int k, input int s);
    if (s >= NCH) return 0;
    return mo[k][s];
  endfunction

  function automatic logic [NCH-1:0] exp_ovf(input int k);
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = (mo[k][i] != 0);
    return v;
  endfunction

  task automatic check_all(input string tag);
    for (int s = 0; s < 8; s++) begin
      sel = SB'(s);
      #1;
      chk($sformatf("%s rd_w sel%0d", tag, s), 64'(rd_w), 64'(exp_rd(0, s)));
      chk($sformatf("%s rd_s sel%0d", tag, s), 64'(rd_s), 64'(exp_rd(1, s)));
      chk($sformatf("%s ro_w sel%0d", tag, s), 64'(ro_w), 64'(exp_ro(0, s)));
      chk($sformatf("%s ro_s sel%0d", tag, s), 64'(ro_s), 64'(exp_ro(1, s)));
    end
    chk({tag, " ovf_w"}, 64'(ovf_w), 64'(exp_ovf(0)));
    chk({tag, " ovf_s"}, 64'(ovf_s), 64'(exp_ovf(1)));
    chk({tag, " sv_w"}, 64'(sv_w), 64'(msv));
    chk({tag, " sv_s"}, 64'(sv_s), 64'(msv));
  endtask

  task automatic step(input string tag, input logic e, input logic [NCH-1:0] v,
                      input logic c, input logic s);
    en = e; evt = v; clr = c; snap = s;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; evt = '0; clr = 1'b0; snap = 1'b0; sel = '0;
    model_reset();
    #3;
    check_all("reset");
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Channel 0 counts 100 events; shadow (if built) stays 0 until snap.
    for (int n = 0; n < 100; n++) step("cnt100", 1'b1, 6'b000001, 1'b0, 1'b0);
    step("snap100", 1'b1, 6'b000000, 1'b0, 1'b1);
    step("idle", 1'b1, 6'b000000, 1'b0, 1'b0);

    // Channel 3 across the all-ones boundary, then beyond; then clear.
    step("clr0", 1'b1, 6'b000000, 1'b1, 1'b0);
    for (int n = 0; n < 300; n++) step("ovf3", 1'b1, 6'b001000, 1'b0, 1'b0);
    for (int n = 0; n < 45; n++) step("ovf1", 1'b1, 6'b000010, 1'b0, 1'b0);
    step("snap_ovf", 1'b1, 6'b000000, 1'b0, 1'b1);
    step("clr1", 1'b1, 6'b000000, 1'b1, 1'b0);

    // Global enable low blocks all increments; clear still acts.
    for (int n = 0; n < 20; n++) step("pre_en0", 1'b1, 6'b110110, 1'b0, 1'b0);
    for (int n = 0; n < 50; n++) step("en0", 1'b0, 6'b111111, 1'b0, 1'b0);
    step("en0_clr", 1'b0, 6'b111111, 1'b1, 1'b0);

    // Combined snap+clr with an event on the same edge, then clr alone.
    for (int n = 0; n < 10; n++) step("ch2_10", 1'b1, 6'b000100, 1'b0, 1'b0);
    step("snap_clr", 1'b1, 6'b000100, 1'b1, 1'b1);
    step("clr_only", 1'b1, 6'b000000, 1'b1, 1'b0);

    // Randomised traffic.
    for (int n = 0; n < 600; n++)
      step("rand", ($urandom_range(0, 9) != 0), NCH'($urandom),
           ($urandom_range(0, 79) == 0), ($urandom_range(0, 19) == 0));

    // Asynchronous reset between edges, then an edge under reset.
    #10;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    step("in_rst", 1'b1, 6'b111111, 1'b1, 1'b1);
    rst = 1'b0;
    for (int n = 0; n < 5; n++) step("post_rst", 1'b1, 6'b101010, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
